// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT datapath.
// The butterfly stage, the Twiddle_Factor multiplier and the twiddle ROM all use it.
//
// Complex word layout: {real[23:12], imag[11:0]}.
// Each component is a signed 12-bit Q(12.10) value.
//
// Contents:
//   - width and saturation constants
//   - component extract and pack helpers
//   - sat13to12: clamps a 13-bit intermediate result to the 12-bit range
package fft_pkg;

  localparam int CPLX_W  = 24;
  localparam int COMP_W  = 12;
  localparam int FRAC_W  = 10;
  localparam int SAT_MAX = 2047;
  localparam int SAT_MIN = -2048;

  typedef logic signed [COMP_W-1:0] comp_t;
  typedef logic        [CPLX_W-1:0] cplx_t;

  function automatic comp_t cplx_re(input cplx_t c);
    return c[CPLX_W-1:COMP_W];
  endfunction

  function automatic comp_t cplx_im(input cplx_t c);
    return c[COMP_W-1:0];
  endfunction

  function automatic cplx_t cplx_pack(input comp_t re, input comp_t im);
    return {re, im};
  endfunction

  // A 13-bit sum or difference of two 12-bit values never wraps.
  // Only the final narrowing to 12 bits needs clamping.
  function automatic comp_t sat13to12(input logic signed [COMP_W:0] v);
    if (v > 13'(SAT_MAX))
      return 12'(SAT_MAX);
    else if (v < 13'(SAT_MIN))
      return 12'(SAT_MIN);
    else
      return v[COMP_W-1:0];
  endfunction

endpackage

// File: rtl/cplx_addsub_sat.sv
// Combinational complex adder/subtractor with saturation.
// Computes sum = a + b and diff = a - b, componentwise.
// Each component is formed at 13 bits, then saturated to 12 bits.
// There is no scaling.
//
// Ports:
//   a, b : packed complex operands {re, im}
//   sum  : saturated a + b
//   diff : saturated a - b
module cplx_addsub_sat
  import fft_pkg::*;
(
  input  logic [CPLX_W-1:0] a,
  input  logic [CPLX_W-1:0] b,
  output logic [CPLX_W-1:0] sum,
  output logic [CPLX_W-1:0] diff
);

  comp_t a_re, a_im, b_re, b_im;
  logic signed [COMP_W:0] re_s, re_d, im_s, im_d;

  assign a_re = cplx_re(a);
  assign a_im = cplx_im(a);
  assign b_re = cplx_re(b);
  assign b_im = cplx_im(b);

  // Sign-extend each operand by one bit so the intermediate result never wraps.
  assign re_s = {a_re[COMP_W-1], a_re} + {b_re[COMP_W-1], b_re};
  assign re_d = {a_re[COMP_W-1], a_re} - {b_re[COMP_W-1], b_re};
  assign im_s = {a_im[COMP_W-1], a_im} + {b_im[COMP_W-1], b_im};
  assign im_d = {a_im[COMP_W-1], a_im} - {b_im[COMP_W-1], b_im};

  assign sum  = cplx_pack(sat13to12(re_s), sat13to12(im_s));
  assign diff = cplx_pack(sat13to12(re_d), sat13to12(im_d));

endmodule

// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
//
// Frame handling:
//   - A frame is 2*N_DELAY samples long.
//   - During the first half (fill), samples are pushed into the delay line.
//   - During the second half (butterfly), the delayed sample a and the incoming
//     sample b are combined.
//   - The sum a+b is emitted immediately.
//   - The difference a-b is pushed back into the delay line.
//   - That difference is emitted as the next frame's fill samples arrive.
//
// Ports:
//   clk         : clock; all state changes on the rising edge
//   rst         : synchronous, active-high reset
//   in_valid    : qualifies in_data; the stage advances only when high
//   in_data     : packed complex input sample
//   out_valid   : registered; high when out_data/out_is_diff/out_tw_idx are valid
//   out_data    : butterfly output (sum or difference)
//   out_is_diff : 1 = difference sample (needs twiddle), 0 = sum sample
//   out_tw_idx  : twiddle exponent j for W_(2*N_DELAY)^j; 0 for sums
module r2sdf_butterfly_stage
  import fft_pkg::*;
#(
  parameter int N_DELAY = 4,
  parameter int IDX_W   = (N_DELAY > 1) ? $clog2(N_DELAY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CPLX_W-1:0] in_data,
  output logic              out_valid,
  output logic [CPLX_W-1:0] out_data,
  output logic              out_is_diff,
  output logic [IDX_W-1:0]  out_tw_idx
);

  // Frame position counter; it wraps naturally because N_DELAY is a power of 2.
  localparam int CNT_W = $clog2(2 * N_DELAY);

  logic [CNT_W-1:0]  cnt;
  logic              phase;
  logic              diff_pending;
  logic [CPLX_W-1:0] dly [N_DELAY];
  logic [CPLX_W-1:0] head;
  logic [CPLX_W-1:0] bf_sum, bf_diff;
  logic [CPLX_W-1:0] push_word;
  logic [IDX_W-1:0]  cur_idx;

  assign phase = cnt[CNT_W-1];
  assign head  = dly[N_DELAY-1];

  // Fill pushes the raw input; butterfly pushes the difference back into the line.
  assign push_word = phase ? bf_diff : in_data;

  // The low cnt bits give the position within the half frame.
  // With N_DELAY = 1 there is no such field, so the index is 0.
  if (N_DELAY > 1) begin : g_idx
    assign cur_idx = cnt[IDX_W-1:0];
  end else begin : g_idx_one
    assign cur_idx = '0;
  end

  cplx_addsub_sat u_addsub (
    .a    (head),
    .b    (in_data),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  // Delay line: a shift register that advances once per accepted sample.
  always_ff @(posedge clk) begin
    if (rst)
      dly[0] <= '0;
    else if (in_valid)
      dly[0] <= push_word;
  end

  for (genvar gi = 1; gi < N_DELAY; gi++) begin : g_dly
    always_ff @(posedge clk) begin
      if (rst)
        dly[gi] <= '0;
      else if (in_valid)
        dly[gi] <= dly[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      diff_pending <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_is_diff  <= 1'b0;
      out_tw_idx   <= '0;
    end else begin
      out_valid <= in_valid && (phase || diff_pending);
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (phase) begin
          out_data    <= bf_sum;
          out_is_diff <= 1'b0;
          out_tw_idx  <= '0;
          // Completing a frame leaves its differences in the line.
          if (&cnt)
            diff_pending <= 1'b1;
        end else begin
          out_data    <= head;
          out_is_diff <= 1'b1;
          out_tw_idx  <= cur_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Self-checking bench for r2sdf_butterfly_stage.
//
// DUTs:
//   - Instance A uses N_DELAY = 2.
//   - Instance B uses N_DELAY = 4.
//
// Reference model:
//   - Per instance, the model keeps the current frame in an array.
//   - Pending differences are kept in a FIFO.
//   - From these it predicts each cycle's outputs.
//
// Checking:
//   - A compare process checks both DUTs on every falling edge.
//   - Hand-computed literal checks pin the model on the basic frame,
//     saturation and first-frame cases.
module tb_r2sdf_butterfly_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_in_valid, b_in_valid;
  logic [23:0] a_in_data, b_in_data;
  logic        a_out_valid, b_out_valid;
  logic [23:0] a_out_data, b_out_data;
  logic        a_out_is_diff, b_out_is_diff;
  logic [0:0]  a_out_tw_idx;
  logic [1:0]  b_out_tw_idx;

  always #5 clk = ~clk;

  r2sdf_butterfly_stage #(.N_DELAY(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_data(a_out_data),
    .out_is_diff(a_out_is_diff), .out_tw_idx(a_out_tw_idx)
  );

  r2sdf_butterfly_stage #(.N_DELAY(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .out_is_diff(b_out_is_diff), .out_tw_idx(b_out_tw_idx)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state, indexed by instance (0 = A, 1 = B).
  logic [23:0] fbuf [2][8];
  logic [23:0] dbuf [2][4];
  int          pos  [2];
  int          drd  [2];
  int          dcnt [2];

  // Predicted outputs: *_nx holds the next cycle, e_* the current cycle.
  logic        nx_v [2], e_v [2];
  logic [23:0] nx_d [2], e_d [2];
  logic        nx_f [2], e_f [2];
  logic [1:0]  nx_i [2], e_i [2];
  logic        e_rst;

  // Log of valid outputs, used by the literal checks.
  logic [26:0] lg  [2][16];
  int          lgn [2];

  function automatic int clamp(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic logic [23:0] bfly(input logic [23:0] a, input logic [23:0] b, input bit sub);
    int ar = int'($signed(a[23:12]));
    int ai = int'($signed(a[11:0]));
    int br = int'($signed(b[23:12]));
    int bi = int'($signed(b[11:0]));
    int r  = clamp(sub ? ar - br : ar + br);
    int i  = clamp(sub ? ai - bi : ai + bi);
    return {12'(r), 12'(i)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k]  = 0;
      drd[k]  = 0;
      dcnt[k] = 0;
      nx_v[k] = 1'b0;
      nx_d[k] = '0;
      nx_f[k] = 1'b0;
      nx_i[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic [23:0] x);
    int n = (k == 0) ? 2 : 4;
    nx_v[k] = 1'b0;
    if (v) begin
      if (pos[k] < n) begin
        fbuf[k][pos[k]] = x;
        if (dcnt[k] > 0) begin
          nx_v[k] = 1'b1;
          nx_d[k] = dbuf[k][drd[k]];
          nx_f[k] = 1'b1;
          nx_i[k] = 2'(pos[k]);
          drd[k]  = (drd[k] + 1) % n;
          dcnt[k] = dcnt[k] - 1;
        end
      end else begin
        nx_v[k] = 1'b1;
        nx_d[k] = bfly(fbuf[k][pos[k]-n], x, 1'b0);
        nx_f[k] = 1'b0;
        nx_i[k] = '0;
        dbuf[k][(drd[k] + dcnt[k]) % n] = bfly(fbuf[k][pos[k]-n], x, 1'b1);
        dcnt[k] = dcnt[k] + 1;
      end
      pos[k] = (pos[k] + 1) % (2 * n);
    end
  endtask

  // One clock cycle: drive the inputs, advance the model, then commit the
  // predictions for the cycle that follows the edge.
  task automatic step(input logic r, input int k, input logic v, input logic [23:0] x);
    rst        = r;
    a_in_valid = (k == 0) && v;
    a_in_data  = (k == 0) ? x : 24'h0;
    b_in_valid = (k == 1) && v;
    b_in_data  = (k == 1) ? x : 24'h0;
    if (r) begin
      model_reset();
    end else begin
      model_step(0, a_in_valid, a_in_data);
      model_step(1, b_in_valid, b_in_data);
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      e_v[j] = nx_v[j];
      e_d[j] = nx_d[j];
      e_f[j] = nx_f[j];
      e_i[j] = nx_i[j];
    end
    e_rst = r;
    @(negedge clk);
    #1;
  endtask

  task automatic check_one(input int k, input logic v, input logic [23:0] d,
                           input logic f, input logic [1:0] i);
    bit ok;
    tests++;
    ok = (v === e_v[k]);
    if (e_v[k])
      ok = ok && (d === e_d[k]) && (f === e_f[k]) && (i === e_i[k]);
    if (e_rst)
      ok = ok && (d === 24'h0) && (f === 1'b0) && (i === 2'd0);
    if (!ok) begin
      fails++;
      $display("FAIL cycle_%s t=%0t got v=%0b d=%06h diff=%0b idx=%0d need v=%0b d=%06h diff=%0b idx=%0d rst=%0b",
               (k == 0) ? "a" : "b", $time, v, d, f, i,
               e_v[k], e_d[k], e_f[k], e_i[k], e_rst);
    end
    if (v === 1'b1 && lgn[k] < 16) begin
      lg[k][lgn[k]] = {f, i, d};
      lgn[k]++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_one(0, a_out_valid, a_out_data, a_out_is_diff, {1'b0, a_out_tw_idx});
      check_one(1, b_out_valid, b_out_data, b_out_is_diff, b_out_tw_idx);
    end
  end

  task automatic check_lit(input string name, input int got, input int need);
    tests++;
    if (got != need) begin
      fails++;
      $display("FAIL %s got %0h need %0h", name, got, need);
    end
  endtask

  task automatic check_basic_log(input string tag);
    check_lit({tag, "_count"}, lgn[0], 4);
    check_lit({tag, "_s0"}, int'(lg[0][0]), int'({1'b0, 2'd0, 24'h180000}));
    check_lit({tag, "_s1"}, int'(lg[0][1]), int'({1'b0, 2'd0, 24'h240000}));
    check_lit({tag, "_d0"}, int'(lg[0][2]), int'({1'b1, 2'd0, 24'h080000}));
    check_lit({tag, "_d1"}, int'(lg[0][3]), int'({1'b1, 2'd1, 24'h1C0000}));
  endtask

  logic [23:0] basic [6];
  int          nd_cnt;

  initial begin
    basic[0] = 24'h100000;
    basic[1] = 24'h200000;
    basic[2] = 24'h080000;
    basic[3] = 24'h040000;
    basic[4] = 24'h000000;
    basic[5] = 24'h000000;
    lgn[0] = 0;
    lgn[1] = 0;

    step(1'b1, 0, 1'b0, 24'h0);
    chk_en = 1'b1;
    step(1'b1, 0, 1'b1, 24'h123456);

    // Basic N_DELAY=2 frame, followed by a two-sample flush.
    lgn[0] = 0;
    for (int j = 0; j < 6; j++)
      step(1'b0, 0, 1'b1, basic[j]);
    step(1'b0, 0, 1'b0, 24'h0);
    check_basic_log("basic");

    // Saturation in both directions.
    step(1'b1, 0, 1'b0, 24'h0);
    lgn[0] = 0;
    step(1'b0, 0, 1'b1, 24'h7FF800);
    step(1'b0, 0, 1'b1, 24'h000000);
    step(1'b0, 0, 1'b1, 24'h001001);
    step(1'b0, 0, 1'b1, 24'h000000);
    step(1'b0, 0, 1'b1, 24'h000000);
    step(1'b0, 0, 1'b1, 24'h000000);
    check_lit("sat_sum", int'(lg[0][0]), int'({1'b0, 2'd0, 24'h7FF801}));
    check_lit("sat_diff", int'(lg[0][2]), int'({1'b1, 2'd0, 24'h7FE800}));

    // Basic frame again, with random stalls between the samples.
    step(1'b1, 0, 1'b0, 24'h0);
    lgn[0] = 0;
    for (int j = 0; j < 6; j++) begin
      while ($urandom_range(0, 1) == 1)
        step(1'b0, 0, 1'b0, 24'($urandom));
      step(1'b0, 0, 1'b1, basic[j]);
    end
    step(1'b0, 0, 1'b0, 24'h0);
    check_basic_log("stall");

    // Reset mid-frame, then a fresh random frame.
    step(1'b1, 0, 1'b0, 24'h0);
    for (int j = 0; j < 3; j++)
      step(1'b0, 0, 1'b1, basic[j]);
    step(1'b1, 0, 1'b1, 24'($urandom));
    lgn[0] = 0;
    for (int j = 0; j < 6; j++)
      step(1'b0, 0, 1'b1, (j < 4) ? 24'($urandom) : 24'h0);
    step(1'b0, 0, 1'b0, 24'h0);
    check_lit("midrst_count", lgn[0], 4);

    // First N_DELAY=4 frame after reset: four sums and no differences.
    step(1'b1, 1, 1'b0, 24'h0);
    lgn[1] = 0;
    for (int j = 0; j < 8; j++)
      step(1'b0, 1, 1'b1, 24'($urandom));
    step(1'b0, 1, 1'b0, 24'h0);
    check_lit("first_count", lgn[1], 4);
    nd_cnt = 0;
    for (int j = 0; j < 4; j++)
      nd_cnt += int'(lg[1][j][26]);
    check_lit("first_no_diff", nd_cnt, 0);

    // 64 back-to-back N_DELAY=4 frames with random stalls.
    // The data mixes small values with full-range values that saturate.
    for (int f = 0; f < 64; f++) begin
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 1, 1'b0, 24'($urandom));
        if ($urandom_range(0, 1) == 0)
          step(1'b0, 1, 1'b1, 24'($urandom));
        else
          step(1'b0, 1, 1'b1, {12'($signed(8'($urandom))), 12'($signed(8'($urandom)))});
      end
    end
    for (int j = 0; j < 4; j++)
      step(1'b0, 1, 1'b1, 24'h0);
    step(1'b0, 1, 1'b0, 24'h0);

    step(1'b1, 0, 1'b0, 24'h0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r2sdf_butterfly_stage.md
Name: r2sdf_butterfly_stage

Overview:
Radix-2 single-path delay-feedback (R2SDF) butterfly stage for the streaming FFT datapath. It sits directly upstream of the Twiddle_Factor multiplier. It consumes one packed complex sample per valid cycle and produces the sum/difference stream. For every output it also supplies the twiddle index the downstream ROM/multiplier must apply.
Complex format everywhere: {real[23:12], imag[11:0]}, each component signed 12-bit Q(12.10).

Parameters:
N_DELAY, 4, feedback delay depth (half frame length); must be a power of 2, >= 1
IDX_W, $clog2(N_DELAY) (min 1), width of twiddle index output

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid this cycle; stage advances only when high
in_data  input  24  packed complex input sample
out_valid  output  1  out_data/out_tw_idx/out_is_diff valid
out_data  output  24  packed complex butterfly output (feeds Twiddle_Factor C)
out_is_diff  output  1  1 = difference sample (needs twiddle), 0 = sum sample (twiddle = 1)
out_tw_idx  output  IDX_W  twiddle exponent j for W_(2*N_DELAY)^j; 0 when out_is_diff=0

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- State:
  - cnt: frame position, 0..2*N_DELAY-1, wraps.
  - phase = cnt MSB (0 = fill, 1 = butterfly).
  - dly: N_DELAY-entry shift register of 24-bit words.
  - diff_pending: flag, set when dly holds differences from a completed frame.
- Everything advances only on cycles with in_valid=1. With in_valid=0, all state holds and out_valid=0 on the next cycle.
- Fill phase (phase=0), in_valid=1:
  - Push in_data into dly; pop head h.
  - If diff_pending: emit h as a difference, out_is_diff=1, out_tw_idx=cnt[IDX_W-1:0].
  - Otherwise nothing is emitted.
- Butterfly phase (phase=1), in_valid=1:
  - Pop head a; compute s = a + in_data and d = a - in_data, componentwise.
  - Emit s with out_is_diff=0, out_tw_idx=0.
  - Push d into dly.
  - When cnt wraps 2*N_DELAY-1 -> 0, set diff_pending=1.
- Arithmetic:
  - Each component is computed at 13 bits (sign-extended), then saturated to 12 bits: >2047 -> 2047 (0x7FF), <-2048 -> -2048 (0x800).
  - No scaling. Real and imag are independent.
- Latency: outputs are registered; an input accepted at cycle t yields its output at t+1.
- out_valid = registered (in_valid && (phase || diff_pending)).
- Differences of the last frame are emitted only when the next frame's fill samples arrive. The upstream block flushes by streaming N_DELAY samples; zeros are acceptable.
- Reset, rst=1 at a clock edge:
  - cnt=0, diff_pending=0, dly cleared to 0.
  - out_valid=0, out_data=0, out_is_diff=0, out_tw_idx=0.
  - rst overrides in_valid.
  - Reset mid-frame discards the partial frame and any pending differences; the first post-reset sample is frame position 0.
- N_DELAY=1: IDX_W=1, out_tw_idx is always 0.

Decomposition:
- fft_pkg:
  - Constants: CPLX_W=24, COMP_W=12, FRAC_W=10, SAT_MAX=2047, SAT_MIN=-2048.
  - Functions: cplx_re/cplx_im extract, cplx_pack, sat13to12.
  - Shared with Twiddle_Factor and the twiddle ROM.
- One sub-module: cplx_addsub_sat. Combinational; takes a and b, returns saturated sum and difference; instantiated once.

Test Plan:
- Basic frame, N_DELAY=2. Input x0..x3 = 0x100_000, 0x200_000, 0x080_000, 0x040_000 on consecutive valid cycles, then y0,y1 = 0. Required outputs:
  - Sums: 0x180_000 and 0x240_000 (is_diff=0, idx 0), one cycle after x2 and x3.
  - Differences: 0x080_000 (is_diff=1, idx 0) and 0x1C0_000 (is_diff=1, idx 1), one cycle after y0 and y1.
- Saturation: a = 0x7FF_800, b = 0x001_001. Required: sum = 0x7FF_801, diff = 0x7FE_800 (imag -2048-1 clamps to 0x800).
- Stalls: same stream as the basic frame with in_valid=0 inserted randomly. Required: identical output sequence; out_valid=0 on every cycle after a stalled input cycle.
- Reset mid-frame: apply rst after x0,x1,x2, then send a fresh frame. Required: no stale sum or difference appears; outputs match the fresh-frame-only golden model; all outputs read 0 during reset.
- Back-to-back frames, N_DELAY=4, 64 random frames with random stalls. Required: outputs are bit-exact to the golden model (saturating sums, delayed differences, out_tw_idx = 0,1,2,3 on the difference runs).
- First frame after reset, N_DELAY=4. Required: exactly 4 valid outputs (sums only) for the 8 inputs, with out_valid=0 during the fill phase.
